fm_decompress: RTL and testbench

FM_DECOMPRESS -- requirements
Module: fm_decompress

---
 rtl/fm_decompress_if.sv | 43 ++++
 rtl/fm_decompress.sv | 107 ++++++++++
 tb/tb_fm_decompress.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_decompress_if.sv
// Handshake bundle for fm_decompress: job control, guard-map stream,
// compressed byte stream and dense window output.
interface fm_decompress_if #(
  parameter int WIN_CNT_W = 16
);
  logic                 ctrl_valid;
  logic                 ctrl_ready;
  logic                 ctrl_finish;
  logic [WIN_CNT_W-1:0] win_num_i;
  logic                 bit_mode_i;

  logic [5:0]           guard_i;
  logic                 guard_i_valid;
  logic                 guard_i_ready;

  logic [7:0]           data_i;
  logic                 data_i_valid;
  logic                 data_i_ready;

  logic [47:0]          win_o;
  logic                 win_o_valid;
  logic                 win_o_ready;

  modport master (
    output ctrl_valid, win_num_i, bit_mode_i,
    output guard_i, guard_i_valid,
    output data_i, data_i_valid,
    output win_o_ready,
    input  ctrl_ready, ctrl_finish,
    input  guard_i_ready, data_i_ready,
    input  win_o, win_o_valid
  );

  modport slave (
    input  ctrl_valid, win_num_i, bit_mode_i,
    input  guard_i, guard_i_valid,
    input  data_i, data_i_valid,
    input  win_o_ready,
    output ctrl_ready, ctrl_finish,
    output guard_i_ready, data_i_ready,
    output win_o, win_o_valid
  );
endinterface

// File: rtl/fm_decompress.sv
// Expands guard-mapped sparse bytes or packed nibbles into dense 6-lane
// windows, one window per output handshake, for a configured window count.
module fm_decompress #(
  parameter int WIN_CNT_W = 16,
  parameter int LANES     = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  fm_decompress_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GUARD = 2'd1;
  localparam logic [1:0] BYTE  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;
  localparam int         WIN_W = LANES * 8;

  logic [1:0]           state;
  logic [WIN_CNT_W-1:0] cnt;
  logic                 mode;
  logic                 finish;
  logic [LANES-1:0]     mask;
  logic [LANES-1:0]     mask_rest;
  logic [WIN_W-1:0]     win;
  logic [2:0]           hi_idx;

  // Ready/valid derive only from state, never from the partner's valid.
  assign bus.ctrl_ready    = (state == IDLE);
  assign bus.ctrl_finish   = finish;
  assign bus.guard_i_ready = (state == GUARD);
  assign bus.data_i_ready  = (state == BYTE);
  assign bus.win_o_valid   = (state == OUT);
  assign bus.win_o         = (state == OUT) ? win : '0;

  // Highest pending slot; in packed mode slot j maps to elements 2j+1/2j.
  always_comb begin
    hi_idx = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mask[i]) hi_idx = 3'(i);
    end
    mask_rest = mask & ~(LANES'(1) << hi_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode   <= 1'b0;
      finish <= 1'b0;
      mask   <= '0;
      win    <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ctrl_valid) begin
            cnt  <= bus.win_num_i;
            mode <= bus.bit_mode_i;
            if (bus.win_num_i == '0) begin
              finish <= 1'b1;
            end else if (bus.bit_mode_i) begin
              win   <= '0;
              mask  <= LANES'(3'b111);
              state <= BYTE;
            end else begin
              state <= GUARD;
            end
          end
        end
        GUARD: begin
          if (bus.guard_i_valid) begin
            win   <= '0;
            mask  <= bus.guard_i;
            state <= (bus.guard_i == '0) ? OUT : BYTE;
          end
        end
        BYTE: begin
          if (bus.data_i_valid) begin
            if (mode)
              win[hi_idx*16 +: 16] <= {4'h0, bus.data_i[7:4], 4'h0, bus.data_i[3:0]};
            else
              win[hi_idx*8 +: 8] <= bus.data_i;
            mask <= mask_rest;
            if (mask_rest == '0) state <= OUT;
          end
        end
        OUT: begin
          if (bus.win_o_ready) begin
            if (cnt != '0) cnt <= cnt - WIN_CNT_W'(1);
            if (cnt <= WIN_CNT_W'(1)) begin
              state  <= IDLE;
              finish <= 1'b1;
            end else if (mode) begin
              win   <= '0;
              mask  <= LANES'(3'b111);
              state <= BYTE;
            end else begin
              state <= GUARD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_decompress.sv
// Self-checking bench for fm_decompress: fixed vector table, hand-built
// stall/reset sequences and randomized jobs against a window-level model.
module tb_fm_decompress;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fm_decompress_if #(.WIN_CNT_W(16)) bus ();

  fm_decompress #(.WIN_CNT_W(16), .LANES(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  gq[$];
  logic [7:0]  bq[$];
  logic [47:0] expq[$];
  logic [47:0] outq[$];
  int          exp_cycles;
  int          exp_bytes;

  typedef struct {
    bit          mode;
    int          num;
    logic [5:0]  g0;
    logic [5:0]  g1;
    logic [47:0] bytes;
    int          nb;
    logic [47:0] e0;
    logic [47:0] e1;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit m, int n, logic [5:0] g0, logic [5:0] g1,
                              logic [47:0] bytes, int nb, logic [47:0] e0, logic [47:0] e1);
    vec_t v;
    v.mode = m; v.num = n; v.g0 = g0; v.g1 = g1;
    v.bytes = bytes; v.nb = nb; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  // Window-level reference: which bytes land in which element, and cost in cycles.
  function automatic void model(input bit mode, input int num);
    int bi = 0;
    expq.delete();
    exp_cycles = 0;
    for (int w = 0; w < num; w++) begin
      logic [47:0] win = '0;
      logic [7:0]  b;
      if (!mode) begin
        exp_cycles++;
        for (int e = 5; e >= 0; e--) begin
          if (gq[w][e]) begin
            win[e*8 +: 8] = bq[bi];
            bi++;
            exp_cycles++;
          end
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          b = bq[bi];
          bi++;
          win[(5-2*k)*8 +: 8] = {4'h0, b[7:4]};
          win[(4-2*k)*8 +: 8] = {4'h0, b[3:0]};
          exp_cycles++;
        end
      end
      exp_cycles++;
      expq.push_back(win);
    end
    exp_bytes = bi;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl_ready"},  64'(bus.ctrl_ready),    64'd1);
    chk({tag, "_ctrl_finish"}, 64'(bus.ctrl_finish),   64'd0);
    chk({tag, "_guard_ready"}, 64'(bus.guard_i_ready), 64'd0);
    chk({tag, "_data_ready"},  64'(bus.data_i_ready),  64'd0);
    chk({tag, "_win_valid"},   64'(bus.win_o_valid),   64'd0);
    chk({tag, "_win_o"},       64'(bus.win_o),         64'd0);
  endtask

  task automatic do_reset();
    bus.ctrl_valid = 1'b0; bus.guard_i_valid = 1'b0;
    bus.data_i_valid = 1'b0; bus.win_o_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_job(input bit mode, input int num, input bit stall, input int hold,
                         input string tag);
    int cycles = 0, gi = 0, bi = 0, fin_stray = 0, gr_pk = 0;
    int bad_rdy = 0, unstable = 0, nz = 0, hcnt = 0;
    bit holding = 1'b0, ended = 1'b0, fin_end = 1'b0;
    logic [47:0] held = '0;
    model(mode, num);
    outq.delete();
    @(negedge clk);
    chk({tag, "_idle_ready"}, 64'(bus.ctrl_ready), 64'd1);
    bus.ctrl_valid = 1'b1;
    bus.win_num_i  = 16'(num);
    bus.bit_mode_i = mode;
    @(negedge clk);
    bus.ctrl_valid = 1'b0;
    while (cycles < 2000) begin
      if (bus.ctrl_ready) begin
        ended   = 1'b1;
        fin_end = bus.ctrl_finish;
        break;
      end
      cycles++;
      bus.win_num_i  = 16'($urandom);
      bus.bit_mode_i = 1'($urandom_range(0, 1));
      if (bus.ctrl_finish) fin_stray++;
      if (mode && bus.guard_i_ready) gr_pk++;
      if (bus.win_o_valid) begin
        if (bus.guard_i_ready || bus.data_i_ready) bad_rdy++;
        if (holding && bus.win_o !== held) unstable++;
        held = bus.win_o;
        holding = 1'b1;
      end else if (bus.win_o !== '0) begin
        nz++;
      end
      bus.guard_i_valid = (gi < gq.size()) && (!stall || $urandom_range(0, 2) != 0);
      bus.guard_i = bus.guard_i_valid ? gq[gi] : 6'($urandom);
      if (bus.guard_i_valid && bus.guard_i_ready) gi++;
      bus.data_i_valid = (bi < bq.size()) && (!stall || $urandom_range(0, 2) != 0);
      bus.data_i = bus.data_i_valid ? bq[bi] : 8'($urandom);
      if (bus.data_i_valid && bus.data_i_ready) bi++;
      bus.win_o_ready = (hcnt >= hold) && (!stall || $urandom_range(0, 1) == 1);
      if (bus.win_o_valid) hcnt++;
      if (bus.win_o_valid && bus.win_o_ready) begin
        outq.push_back(bus.win_o);
        holding = 1'b0;
        hcnt = 0;
      end
      bus.ctrl_valid = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    bus.ctrl_valid = 1'b0; bus.guard_i_valid = 1'b0;
    bus.data_i_valid = 1'b0; bus.win_o_ready = 1'b0;
    chk({tag, "_completed"}, 64'(ended), 64'd1);
    if (!ended) begin
      do_reset();
    end else begin
      chk({tag, "_finish_at_end"}, 64'(fin_end), 64'd1);
      @(negedge clk);
      chk({tag, "_finish_one_cycle"}, 64'(bus.ctrl_finish), 64'd0);
      chk({tag, "_ready_after"},      64'(bus.ctrl_ready),  64'd1);
    end
    chk({tag, "_stray_finish"}, 64'(fin_stray), 64'd0);
    chk({tag, "_nwin"}, 64'(outq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      chk($sformatf("%s_win%0d", tag, i), 64'(outq[i]), 64'(expq[i]));
    chk({tag, "_guards_used"}, 64'(gi), 64'(mode ? 0 : num));
    chk({tag, "_bytes_used"},  64'(bi), 64'(exp_bytes));
    chk({tag, "_ready_in_out"}, 64'(bad_rdy), 64'd0);
    chk({tag, "_win_stable"},   64'(unstable), 64'd0);
    chk({tag, "_win_zero_idle"}, 64'(nz), 64'd0);
    chk({tag, "_packed_guard_rdy"}, 64'(gr_pk), 64'd0);
    if (!stall && hold == 0 && ended)
      chk({tag, "_cycles"}, 64'(cycles), 64'(exp_cycles));
  endtask

  initial begin
    bus.ctrl_valid = 1'b0; bus.win_num_i = '0; bus.bit_mode_i = 1'b0;
    bus.guard_i = '0; bus.guard_i_valid = 1'b0;
    bus.data_i = '0; bus.data_i_valid = 1'b0; bus.win_o_ready = 1'b0;

    vecs[0] = mk(1'b0, 1, 6'b100001, 6'b0, 48'h1234_0000_0000, 2, 48'h12_00_00_00_00_34, 48'h0);
    vecs[1] = mk(1'b0, 2, 6'b000000, 6'b111111, 48'h0102_0304_0506, 6, 48'h0, 48'h01_02_03_04_05_06);
    vecs[2] = mk(1'b1, 1, 6'b0, 6'b0, 48'hABCD_EF00_0000, 3, 48'h0A_0B_0C_0D_0E_0F, 48'h0);
    vecs[3] = mk(1'b0, 0, 6'b0, 6'b0, 48'h0, 0, 48'h0, 48'h0);
    vecs[4] = mk(1'b0, 1, 6'b000100, 6'b0, 48'h5A00_0000_0000, 1, 48'h00_00_00_5A_00_00, 48'h0);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      gq.delete(); bq.delete();
      if (vecs[i].num > 0) gq.push_back(vecs[i].g0);
      if (vecs[i].num > 1) gq.push_back(vecs[i].g1);
      for (int j = 0; j < vecs[i].nb; j++) bq.push_back(vecs[i].bytes[47-8*j -: 8]);
      run_job(vecs[i].mode, vecs[i].num, 1'b0, 0, tag);
      chk({tag, "_tbl_nwin"}, 64'(outq.size()), 64'(vecs[i].num));
      if (outq.size() > 0) chk({tag, "_tbl_w0"}, 64'(outq[0]), 64'(vecs[i].e0));
      if (outq.size() > 1) chk({tag, "_tbl_w1"}, 64'(outq[1]), 64'(vecs[i].e1));
    end

    // Output backpressure: five stalled OUT cycles per window.
    gq.delete(); bq.delete();
    gq.push_back(6'b101010); gq.push_back(6'b010101);
    for (int j = 0; j < 6; j++) bq.push_back(8'(8'h30 + j));
    run_job(1'b0, 2, 1'b0, 5, "hold5_sparse");
    gq.delete(); bq.delete();
    for (int j = 0; j < 6; j++) bq.push_back(8'(8'h91 + 8'h11 * j));
    run_job(1'b1, 2, 1'b0, 5, "hold5_packed");

    // Reset while a 3-window job sits in BYTE.
    begin
      int fin_seen = 0;
      @(negedge clk);
      bus.ctrl_valid = 1'b1; bus.win_num_i = 16'd3; bus.bit_mode_i = 1'b0;
      @(negedge clk);
      bus.ctrl_valid = 1'b0;
      bus.guard_i_valid = 1'b1; bus.guard_i = 6'h3f;
      for (int i = 0; i < 20 && !bus.data_i_ready; i++) @(negedge clk);
      chk("rstmid_reached_byte", 64'(bus.data_i_ready), 64'd1);
      bus.guard_i_valid = 1'b0;
      bus.data_i_valid = 1'b1; bus.data_i = 8'h77;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.data_i_valid = 1'b0;
      check_reset_outputs("rstmid");
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (bus.ctrl_finish) fin_seen++;
      end
      chk("rstmid_no_finish", 64'(fin_seen), 64'd0);
      gq.delete(); bq.delete();
      gq.push_back(6'b110011);
      for (int j = 0; j < 4; j++) bq.push_back(8'(8'hC0 + j));
      run_job(1'b0, 1, 1'b0, 0, "rstmid_newjob");
    end

    // Randomized jobs with valid gaps and output backpressure.
    for (int t = 0; t < 40; t++) begin
      bit m;
      int n, nbytes, st, hd;
      m = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      st = int'($urandom_range(0, 1));
      hd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      gq.delete(); bq.delete();
      nbytes = 0;
      for (int w = 0; w < n; w++) begin
        logic [5:0] g;
        case ($urandom_range(0, 3))
          0:       g = 6'h00;
          1:       g = 6'h3f;
          default: g = 6'($urandom);
        endcase
        if (!m) begin
          gq.push_back(g);
          nbytes += $countones(g);
        end else begin
          nbytes += 3;
        end
      end
      for (int j = 0; j < nbytes; j++) bq.push_back(8'($urandom));
      run_job(m, n, 1'(st), hd, $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
